// File: rtl/wb_evict_buffer.sv
// wb_evict_buffer: FIFO of dirty victim lines drained as fixed-length write bursts, with lookup forwarding.
module wb_evict_buffer #(
  parameter int Depth     = 2,
  parameter int LineWidth = 128,
  parameter int DataWidth = 64,
  parameter int AddrWidth = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 evict_valid_i,
  output logic                 evict_ready_o,
  input  logic [AddrWidth-1:0] evict_addr_i,
  input  logic [LineWidth-1:0] evict_data_i,
  output logic                 wr_valid_o,
  input  logic                 wr_ready_i,
  output logic [AddrWidth-1:0] wr_addr_o,
  output logic [DataWidth-1:0] wr_data_o,
  output logic                 wr_last_o,
  input  logic                 wr_resp_valid_i,
  input  logic                 wr_resp_err_i,
  output logic                 err_o,
  input  logic [AddrWidth-1:0] lookup_addr_i,
  output logic                 lookup_hit_o,
  output logic [LineWidth-1:0] lookup_data_o,
  output logic                 empty_o
);
  localparam int NBeats = LineWidth / DataWidth;
  localparam int PW = $clog2(Depth);
  localparam int BW = $clog2(NBeats);
  localparam int OW = $clog2(LineWidth / 8);
  localparam logic [PW:0] Full = (PW+1)'(Depth);
  localparam logic [BW-1:0] LastBeat = BW'(NBeats - 1);
  localparam logic [AddrWidth-1:0] LineMask = {{(AddrWidth-OW){1'b1}}, {OW{1'b0}}};

  typedef enum logic [1:0] {IDLE, BEATS, RESP} state_t;

  state_t state_q, state_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0] count_q, count_d;
  logic [BW-1:0] beat_q, beat_d;
  logic err_q, err_d;
  logic push, free, beat_done;
  logic [AddrWidth-1:0] addr_q [Depth];
  logic [LineWidth-1:0] data_q [Depth];

  assign evict_ready_o = count_q != Full;
  assign wr_valid_o = state_q == BEATS;
  assign wr_last_o = wr_valid_o && beat_q == LastBeat;
  assign wr_addr_o = wr_valid_o ? addr_q[rptr_q] : '0;
  assign wr_data_o = wr_valid_o ? data_q[rptr_q][beat_q*DataWidth +: DataWidth] : '0;
  assign err_o = err_q;
  assign empty_o = count_q == '0 && state_q == IDLE;

  always_comb begin
    push = evict_valid_i && evict_ready_o;
    beat_done = wr_valid_o && wr_ready_i;
    free = state_q == RESP && wr_resp_valid_i;
    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = free ? rptr_q + 1'b1 : rptr_q;
    count_d = (push && !free) ? count_q + 1'b1 : (!push && free) ? count_q - 1'b1 : count_q;
    beat_d = state_q == IDLE ? '0 : beat_done ? (wr_last_o ? '0 : beat_q + 1'b1) : beat_q;
    state_d = state_q == IDLE ? (count_q != '0 ? BEATS : IDLE)
            : state_q == BEATS ? (beat_done && wr_last_o ? RESP : BEATS)
            : (free ? IDLE : RESP);
    err_d = free && wr_resp_err_i;
  end

  // Scan newest to oldest so the oldest matching entry overwrites any younger one.
  always_comb begin
    lookup_hit_o = 1'b0;
    lookup_data_o = '0;
    for (int i = Depth - 1; i >= 0; i--) begin
      if ((PW+1)'(i) < count_q && addr_q[rptr_q + PW'(i)] == (lookup_addr_i & LineMask)) begin
        lookup_hit_o = 1'b1;
        lookup_data_o = data_q[rptr_q + PW'(i)];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
      beat_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
      beat_q <= beat_d;
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_q[wptr_q] <= evict_addr_i & LineMask;
      data_q[wptr_q] <= evict_data_i;
    end
  end
endmodule

// File: doc/wb_evict_buffer.md
# wb_evict_buffer

Write-back eviction buffer between the write-back data cache's miss handler and the AXI write path. It accepts dirty victim lines and frees the cache way immediately. It drains each line as a fixed-length burst of data-width beats and frees the entry only once the write response returns. An address lookup port lets the refill path detect misses on lines that are still buffered and forward their data.

## Interface
- Depth, 2: number of line entries (power of two, ≥2)
- LineWidth, 128: cache line width in bits
- DataWidth, 64: write beat width in bits; LineWidth/DataWidth = NBeats (≥2)
- AddrWidth, 64: physical address width
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, synchronous and active-high
- evict_valid_i  in  1  victim line offered
- evict_ready_o  out  1  buffer can accept a victim
- evict_addr_i  in  AddrWidth  victim line address; low log2(LineWidth/8) bits are ignored and stored as 0
- evict_data_i  in  LineWidth  victim line data
- wr_valid_o  out  1  write beat valid
- wr_ready_i  in  1  downstream accepts beat
- wr_addr_o  out  AddrWidth  line-aligned base address of the current burst
- wr_data_o  out  DataWidth  current beat; beat k = line bits [k*DataWidth +: DataWidth]
- wr_last_o  out  1  final beat of burst
- wr_resp_valid_i  in  1  write response for the outstanding burst
- wr_resp_err_i  in  1  response is an error
- err_o  out  1  one-cycle pulse on error response
- lookup_addr_i  in  AddrWidth  refill address to check (line-aligned compare)
- lookup_hit_o  out  1  line is held in any occupied entry
- lookup_data_o  out  LineWidth  data of the hitting entry; 0 on no hit
- empty_o  out  1  no occupied entries and drain FSM IDLE (fence/flush gate)

## Operation
- Storage is a circular FIFO: write pointer, read pointer, occupancy count (width log2(Depth)+1). Pointers wrap modulo Depth.
- Push:
  - evict_ready_o = (count != Depth), from registered state only.
  - A push occurs when evict_valid_i && evict_ready_o. The entry is written at the write pointer and the pointer increments.
- Drain FSM:
  - IDLE: if count != 0, go to BEATS with beat counter = 0, using the entry at the read pointer.
  - BEATS: wr_valid_o = 1. On wr_ready_i, the beat counter increments. When the beat with counter = NBeats−1 is accepted (wr_last_o = 1), go to RESP.
  - RESP: wait for wr_resp_valid_i. Then free the entry (read pointer +1, count −1), pulse err_o if wr_resp_err_i, and return to IDLE.
- A freed entry's data is not cleared. Occupancy is defined only by the pointers and count.
- Lookup is combinational over all occupied entries, including the entry being drained and the entry awaiting response.
  - Address match ignores the low offset bits.
  - Duplicate line addresses are not legal (the cache never evicts a line it does not hold). If several entries match anyway, the oldest wins.
- A push and a free in the same cycle leave count unchanged; both pointers advance.
- The same-cycle free does not raise evict_ready_o when full. Ready opens the following cycle.
- wr_resp_valid_i outside RESP is ignored.
- err_o is informational only. The entry is freed regardless of the response.
- Reset mid-operation:
  - All entries free; FSM to IDLE. Any in-flight burst is abandoned.
  - A late response arriving after reset is ignored (FSM not in RESP).

## Timing
- Reset values: evict_ready_o=1, wr_valid_o=0, wr_last_o=0, wr_addr_o=0, wr_data_o=0, err_o=0, empty_o=1, lookup_hit_o=0 (no entries occupied).
- Push at cycle t:
  - Entry occupied and visible to lookup at t+1; not visible at t.
  - empty_o falls at t+1.
  - First beat wr_valid_o at t+2 (IDLE→BEATS at t+1).
- Beat throughput is one per cycle while wr_ready_i=1. wr_addr_o, wr_data_o and wr_last_o remain stable while wr_valid_o && !wr_ready_i.
- Response in cycle r frees the entry at r+1: lookup miss, ready rises if previously full, err_o high during r+1 only. The next burst's first beat is no earlier than r+2.
- All outputs except lookup_hit_o and lookup_data_o are functions of registered state. Those two are combinational from lookup_addr_i.

## Test plan
- Single eviction: push addr 0x8000_0040, data {0x2222,0x1111}, wr_ready_i=1, response 3 cycles after last -> beats 0x1111 then 0x2222 (last=1), wr_addr_o=0x8000_0040, empty_o high again after response.
- Full: push 3 lines back-to-back with no response -> third push stalls (evict_ready_o=0) until the first response; lines drain in FIFO order.
- Lookup: push 0x8000_0100, hold response -> lookup 0x8000_010C hits with pushed data in BEATS and RESP; misses the cycle after response; lookup in the push cycle misses.
- Backpressure: wr_ready_i toggling 0/1 -> beat data and address held stable while stalled, exactly NBeats handshakes per line, last asserted only on beat 1.
- Error and reset: response with err=1 -> err_o one-cycle pulse, entry freed. Reset asserted in BEATS -> next cycle outputs at reset values; subsequent stray response ignored, buffer stays empty.
